// File: rtl/tone_generator.sv
// tone_generator: square-wave synthesiser for the buzzer pin.
// The pitch comes from the latched note/octave pair. Changes and silencing are
// applied only at the end of a completed low phase, so no pulse is truncated.
// Dropping en or asserting reset stops the tone at once.
module tone_generator #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic             speaker,
  output logic             active,
  output logic [3:0]       cur_note,
  output logic [1:0]       cur_octave,
  output logic             period_tick
);

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // Mid-octave half-periods in clock cycles, fixed at elaboration
  localparam logic [CNT_W-1:0] HALF_DO = CNT_W'(CLK_HZ / (2 * 262));
  localparam logic [CNT_W-1:0] HALF_RE = CNT_W'(CLK_HZ / (2 * 294));
  localparam logic [CNT_W-1:0] HALF_MI = CNT_W'(CLK_HZ / (2 * 330));
  localparam logic [CNT_W-1:0] HALF_FA = CNT_W'(CLK_HZ / (2 * 349));
  localparam logic [CNT_W-1:0] HALF_SO = CNT_W'(CLK_HZ / (2 * 392));
  localparam logic [CNT_W-1:0] HALF_LA = CNT_W'(CLK_HZ / (2 * 440));
  localparam logic [CNT_W-1:0] HALF_SI = CNT_W'(CLK_HZ / (2 * 494));

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       note_n;
  logic [1:0]       oct_n;
  logic [CNT_W-1:0] base_half;
  logic [CNT_W-1:0] half;
  logic             valid;
  logic             last;
  logic             tick_n;

  // Base half-period for the latched note
  always_comb begin
    base_half = '0;
    case (cur_note)
      4'd1:    base_half = HALF_DO;
      4'd2:    base_half = HALF_RE;
      4'd3:    base_half = HALF_MI;
      4'd4:    base_half = HALF_FA;
      4'd5:    base_half = HALF_SO;
      4'd6:    base_half = HALF_LA;
      4'd7:    base_half = HALF_SI;
      default: base_half = '0;
    endcase
  end

  // Octave scaling of the latched note's half-period
  always_comb begin
    half = base_half;
    case (cur_octave)
      2'b00:   half = base_half << 1;
      2'b01:   half = base_half;
      2'b10:   half = base_half >> 1;
      default: half = base_half >> 2;
    endcase
  end

  // Request qualification and end-of-phase detection
  always_comb begin
    valid = en && (note != 4'd0) && !note[3];
    last  = (cnt == half - CNT_W'(1));
  end

  // Next-state, counter and latch logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    note_n  = cur_note;
    oct_n   = cur_octave;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (valid) begin
          state_n = ST_HIGH;
          note_n  = note;
          oct_n   = octave;
        end
      end
      ST_HIGH: begin
        if (last) begin
          state_n = ST_LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (last) begin
          cnt_n = '0;
          if (valid) begin
            state_n = ST_HIGH;
            note_n  = note;
            oct_n   = octave;
          end else begin
            state_n = ST_IDLE;
            note_n  = '0;
            oct_n   = '0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        note_n  = '0;
        oct_n   = '0;
      end
    endcase
    // Mute overrides everything except reset
    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      note_n  = '0;
      oct_n   = '0;
    end
  end

  // period_tick is registered, so it is raised one edge early: it is set when
  // the upcoming cycle is the final count of LOW. The latched note cannot
  // change while staying in LOW, so the current half applies.
  always_comb begin
    tick_n = (state_n == ST_LOW) && (cnt_n == half - CNT_W'(1));
  end

  // State and registered outputs; synchronous active-low reset wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_note    <= '0;
      cur_octave  <= '0;
      speaker     <= 1'b0;
      active      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cur_note    <= note_n;
      cur_octave  <= oct_n;
      speaker     <= (state_n == ST_HIGH);
      active      <= (state_n != ST_IDLE);
      period_tick <= tick_n;
    end
  end

endmodule

// File: doc/tone_generator.md
# tone_generator

Square-wave synthesiser that sits directly downstream of the piano controller. It consumes the registered `note_out`/`octave_out` pair and drives the buzzer pin with a 50 % duty square wave at the requested pitch. Pitch changes and silencing take effect only at period boundaries, so the speaker never sees a truncated pulse. Status outputs expose the note currently sounding, for LEDs and for verification.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `CNT_W`, default 20: half-period counter width; must hold the octave-00 note-1 half-period.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `en`  in  1  sound enable; 0 mutes immediately.
- `note`  in  4  0 = rest, 1..7 = do..si, 8..15 treated as rest.
- `octave`  in  2  00 low, 01 mid, 10 high, 11 highest.
- `speaker`  out  1  square-wave drive to buzzer.
- `active`  out  1  1 while a note is sounding.
- `cur_note`  out  4  latched note currently sounding; 0 when idle.
- `cur_octave`  out  2  latched octave currently sounding; 00 when idle.
- `period_tick`  out  1  one-cycle pulse at the end of every completed low phase.

## Operation
- Base mid-octave frequencies, notes 1..7: 262, 294, 330, 349, 392, 440, 494 Hz.
- `base_half` = CLK_HZ / (2*f), integer-truncated, computed at elaboration.
- Octave scaling applies to `base_half`, with truncation:
  - 00: `base_half << 1`
  - 01: `base_half`
  - 10: `base_half >> 1`
  - 11: `base_half >> 2`
- `half` is computed from the latched note and octave only.
- A valid note is `note` in 1..7 with `en` = 1.
- States:
  - IDLE: `speaker` = 0, `active` = 0, `cur_note` = 0, `cur_octave` = 00.
  - HIGH: `speaker` = 1.
  - LOW: `speaker` = 0.
- IDLE transitions: on a valid note, latch `note`/`octave` into `cur_note`/`cur_octave`, clear the counter, go to HIGH. Otherwise stay in IDLE.
- HIGH transitions: the counter increments each cycle. When counter == `half`-1, clear the counter and go to LOW.
- LOW transitions: the counter increments each cycle. When counter == `half`-1, pulse `period_tick`, clear the counter, and sample the inputs:
  - valid note: latch it (may differ from the previous note) and go to HIGH;
  - otherwise: go to IDLE.
- `note`/`octave` changes during HIGH or LOW are ignored until the next LOW-end boundary.
- `en` = 0 in any state: next cycle goes to IDLE, regardless of phase; a partial pulse is allowed here. No `period_tick` is generated.
- Reset (`reset` = 0) in any state, including mid-period: next edge forces IDLE values with the counter at 0. Reset has priority over `en` and boundary logic.

## Timing
- Reset values: `speaker` 0, `active` 0, `cur_note` 0, `cur_octave` 00, `period_tick` 0, counter 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start latency: valid note sampled at edge N, so `speaker`/`active` = 1 from edge N+1.
- Steady state: HIGH lasts exactly `half` cycles and LOW lasts exactly `half` cycles, giving a period of 2·`half`.
- `period_tick` is high in the same cycle that LOW's final count is evaluated. The new HIGH, or IDLE, is visible the following cycle.
- A note change is audible at most 2·`half`+1 cycles after it is applied.
- Stop latency on rest: the current period completes, then `speaker` = 0 and `active` = 0 from the next edge.
- Mute latency: one cycle after `en` falls.
- Back-to-back notes: no IDLE gap; LOW's last cycle is followed directly by HIGH of the new note.

## Test plan
Use `CLK_HZ` = 8800 for all scenarios. Expected half-periods: note 6/oct 01 = 10, note 1/oct 01 = 16, note 6/oct 10 = 5, note 6/oct 11 = 2, note 6/oct 00 = 20.

- **Reset values:** hold `reset` = 0 with `en` = 1, `note` = 6 → all outputs 0 throughout. Release `reset` → `speaker` rises one cycle after the first sampled edge.
- **Basic pitch:** `note` = 6, `octave` = 01, `en` = 1 → `speaker` alternates 10 high / 10 low, repeatedly. `period_tick` every 20 cycles. `cur_note` = 6, `active` = 1.
- **Octave scaling:** repeat note 6 with octave 00, 10, 11 → high times of 20, 5, 2 cycles respectively.
- **Change at boundary:** switch to `note` = 1 on cycle 3 of the HIGH phase → the current 10/10 period completes unchanged, then 16/16 follows with no gap. `cur_note` changes to 1 in the cycle after `period_tick`.
- **Rest and invalid note:** set `note` = 0 mid-HIGH, then separately `note` = 9 → each period finishes, then IDLE with `active` = 0 and `cur_note` = 0. Neither value ever starts a period from IDLE.
- **Mute and mid-period reset:** drop `en` on HIGH cycle 4 → `speaker` = 0 next cycle with no `period_tick`. Reassert `en` → a fresh full 10-cycle HIGH. Assert `reset` during LOW → IDLE next edge, with the counter restarting from 0 afterwards.
